seq_divider: RTL
================

# seq_divider

Multi-cycle restoring divider for unsigned operands. It runs one shift/trial-subtract/restore step per clock, using the same N-bit add/subtract datapath as the ripple-carry adder-subtractor. It is the inverse arithmetic companion to the adder-subtractor, for datapaths that need quotient/remainder without a combinational array divider. The block sits behind a simple start/done handshake. Results hold until the next operation completes.

## Interface
- N, default 4: operand, quotient and remainder width in bits (N >= 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only when not busy
- dividend  input  N  unsigned dividend; sampled with start
- divisor  input  N  unsigned divisor; sampled with start
- busy  output  1  high while an operation is iterating
- done  output  1  one-cycle pulse: results valid and updated
- quotient  output  N  registered quotient
- remainder  output  N  registered remainder
- div_by_zero  output  1  registered flag: last operation had divisor == 0

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: FSM = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, internal counter = 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start = 1:
  - Latch D = divisor, Q = dividend, R = 0 (R is N+1 bits).
  - If divisor != 0: go to RUN, step count = 0.
  - If divisor == 0: go to DONE directly.
- RUN, each cycle:
  - R' = {R[N-1:0], Q[N-1]}; T = R' - {1'b0, D}, computed N+1 bits wide.
  - If T[N] = 0: R = T, Q = {Q[N-2:0], 1}.
  - Else: R = R', Q = {Q[N-2:0], 0}.
  - Increment count; after the N-th step, go to DONE.
- Entry to DONE, normal case: quotient = Q, remainder = R[N-1:0], div_by_zero = 0.
- Entry to DONE, zero divisor: quotient = all ones, remainder = dividend, div_by_zero = 1.
- DONE lasts exactly one cycle (done = 1). Next state is RUN/DONE if start = 1, else IDLE. This allows back-to-back operations.
- start in RUN is ignored; the latched operands are unaffected by input changes during RUN.
- quotient, remainder and div_by_zero change only on entry to DONE. They hold in all other states, including across later IDLE periods.
- Remainder is always < divisor for divisor != 0; dividend = quotient*divisor + remainder exactly.

## Timing
- Latency, divisor != 0: start sampled at edge k → busy = 1 after edge k → done = 1 after edge k+N, for one cycle.
- Latency, divisor == 0: done = 1 after edge k+1. busy stays 0.
- Throughput: one result per N+1 cycles when start is held high or re-asserted in the DONE cycle.
- busy = 1 exactly in RUN; done = 1 exactly in DONE. Both are registered (state-decoded) and glitch-free relative to clk.
- Reset mid-operation: outputs and FSM clear immediately (asynchronous). No done is produced for the aborted operation. A new start is accepted on the first edge after rst deasserts.
- Simultaneous start and rst: rst wins.

## Test plan
- Reset: assert rst mid-cycle → busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0 immediately, before the next clk edge.
- N=4, dividend = 11, divisor = 3, start one cycle → done pulses exactly 4 cycles after the sampling edge; quotient = 3, remainder = 2, div_by_zero = 0; busy high for exactly 4 cycles.
- Boundaries:
  - 15/1 → q = 15, r = 0.
  - 5/7 → q = 0, r = 5.
  - 15/15 → q = 1, r = 0.
  - 0/4 → q = 0, r = 0.
- Zero divisor: 9/0 → done 1 cycle later; q = 4'hF, r = 9, div_by_zero = 1, busy never high. A following 6/2 clears div_by_zero and gives q = 3, r = 0.
- Handshake:
  - Pulse start again during RUN with different operands → ignored; first result unchanged.
  - Start asserted in the DONE cycle (12/5 then 13/4) → second result q = 3, r = 1 exactly N+1 cycles after the first done.
- Reset mid-RUN at step 2 → no done pulse; next 7/2 after reset yields q = 3, r = 1.
- Exhaustive: all 256 dividend/divisor pairs at N=4 checked against integer / and %, with divisor 0 checked against the div_by_zero rule.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for unsigned N-bit operands.
// One shift / trial-subtract / restore step per clock behind a start/done
// handshake. Results are registered and hold until the next completion.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  d_reg;
  logic [N-1:0]  q_reg;
  logic [N:0]    r_reg;
  logic [CW-1:0] count;
  logic          zero_pend;

  logic [N:0]    r_shift;
  logic [N:0]    trial;
  logic [N:0]    r_next;
  logic [N-1:0]  q_next;
  logic          last_step;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    r_shift   = {r_reg[N-1:0], q_reg[N-1]};
    trial     = r_shift - {1'b0, d_reg};
    r_next    = r_shift;
    q_next    = {q_reg[N-2:0], 1'b0};
    if (!trial[N]) begin
      r_next = trial;
      q_next = {q_reg[N-2:0], 1'b1};
    end
    last_step = (count == CW'(N - 1));
  end

  // Control FSM, operand registers and registered result outputs.
  // A zero divisor spends one non-busy cycle (zero_pend, FSM in IDLE) before
  // DONE, so its done pulse lands one edge after start is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      zero_pend   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + CW'(1);
          if (last_step) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (zero_pend) begin
            zero_pend   <= 1'b0;
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end else if (start) begin
            d_reg <= divisor;
            q_reg <= dividend;
            r_reg <= '0;
            count <= '0;
            if (divisor != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state     <= IDLE;
              zero_pend <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
